// File: rtl/dot_accumulator_pkg.sv
// Shared types and helpers for the dot-product accumulation stage.
// PROD_W tracks the output width of the 4x4 multiplier feeding this block.
package dot_accumulator_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StHold
   } state_e;

   localparam int unsigned PROD_W = 8;

   // Smallest r with 2**r >= value.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dot_acc_datapath.sv
// Accumulator datapath: ACC_W adder with carry-out and the acc/cnt/ovf registers.
// The controlling FSM selects clear, load or add; at most one is expected per cycle.
module dot_acc_datapath import dot_accumulator_pkg::*; #(
   parameter int unsigned ACC_W = 12,
   parameter int unsigned CNT_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              add,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  acc,
   output logic [CNT_W-1:0]  cnt,
   output logic              ovf
);

   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic [ACC_W:0]   sum_wide;

   // Top bit of the widened sum is the carry out of bit ACC_W-1.
   assign sum_wide = {1'b0, acc_q} + {1'b0, ACC_W'(prod)};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (clear) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (load) begin
         acc_q <= ACC_W'(prod);
         cnt_q <= CNT_W'(1);
         ovf_q <= 1'b0;
      end else if (add) begin
         acc_q <= sum_wide[ACC_W-1:0];
         cnt_q <= cnt_q + 1'b1;
         ovf_q <= ovf_q | sum_wide[ACC_W];
      end
   end

   assign acc = acc_q;
   assign cnt = cnt_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/dot_accumulator.sv
// Sums up to N_TERMS multiplier products per group and presents each group result
// over a valid/ready port. FSM and handshake live here; arithmetic is in the datapath.
module dot_accumulator import dot_accumulator_pkg::*; #(
   parameter int unsigned N_TERMS = 4,
   parameter int unsigned ACC_W   = 12,
   localparam int unsigned CNT_W  = clog2(N_TERMS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   state_e           state_q, state_d;
   logic             clear, load, add;
   logic             close;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // cnt is zero in StIdle, so cnt+1 is the post-transfer count in both accepting states.
   assign cnt_next = cnt + 1'b1;
   assign close    = in_last || (cnt_next == CNT_W'(N_TERMS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clear     = 1'b0;
      load      = 1'b0;
      add       = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               state_d = close ? StHold : StAccum;
            end
         end
         StAccum: begin
            in_ready = 1'b1;
            if (in_valid) begin
               add = 1'b1;
               if (close) begin
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            out_valid = 1'b1;
            if (out_ready) begin
               clear   = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   dot_acc_datapath #(
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) u_datapath (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .load  (load),
      .add   (add),
      .prod  (in_prod),
      .acc   (out_sum),
      .cnt   (cnt),
      .ovf   (out_ovf)
   );

   assign out_count = cnt;

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator: default, ACC_W=8 and N_TERMS=1 instances.
module tb_dot_accumulator;

   logic clk;
   logic rst;

   // Instance A: defaults (N_TERMS=4, ACC_W=12)
   logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
   logic [7:0]  a_in_prod;
   logic [11:0] a_out_sum;
   logic [2:0]  a_out_count;

   // Instance B: ACC_W=8
   logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
   logic [7:0]  b_in_prod;
   logic [7:0]  b_out_sum;
   logic [2:0]  b_out_count;

   // Instance C: N_TERMS=1
   logic        c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_ovf;
   logic [7:0]  c_in_prod;
   logic [11:0] c_out_sum;
   logic [0:0]  c_out_count;

   int n_checks = 0;
   int n_pass   = 0;

   dot_accumulator u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_prod   (a_in_prod),
      .in_last   (a_in_last),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_sum   (a_out_sum),
      .out_count (a_out_count),
      .out_ovf   (a_out_ovf)
   );

   dot_accumulator #(.N_TERMS(4), .ACC_W(8)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_prod   (b_in_prod),
      .in_last   (b_in_last),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_sum   (b_out_sum),
      .out_count (b_out_count),
      .out_ovf   (b_out_ovf)
   );

   dot_accumulator #(.N_TERMS(1), .ACC_W(12)) u_dut_c (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (c_in_valid),
      .in_ready  (c_in_ready),
      .in_prod   (c_in_prod),
      .in_last   (c_in_last),
      .out_valid (c_out_valid),
      .out_ready (c_out_ready),
      .out_sum   (c_out_sum),
      .out_count (c_out_count),
      .out_ovf   (c_out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_beat(input logic [7:0] p, input logic l);
      a_in_valid = 1'b1;
      a_in_prod  = p;
      a_in_last  = l;
      step();
   endtask

   task automatic b_beat(input logic [7:0] p, input logic l);
      b_in_valid = 1'b1;
      b_in_prod  = p;
      b_in_last  = l;
      step();
   endtask

   logic [7:0] exp_q[$];
   logic [7:0] exp_v;
   logic       accept;
   int         sent;
   int         recv;

   initial begin
      rst = 1'b1;
      a_in_valid = 0; a_in_prod = 0; a_in_last = 0; a_out_ready = 1;
      b_in_valid = 0; b_in_prod = 0; b_in_last = 0; b_out_ready = 1;
      c_in_valid = 0; c_in_prod = 0; c_in_last = 0; c_out_ready = 0;
      #12 rst = 1'b0;
      #1;
      // Reset state
      check("rst_out_valid", 32'(a_out_valid), 0);
      check("rst_in_ready", 32'(a_in_ready), 1);
      check("rst_sum", 32'(a_out_sum), 0);
      check("rst_count", 32'(a_out_count), 0);
      check("rst_ovf", 32'(a_out_ovf), 0);
      step();

      // Full group: 4 x 225, forced close
      a_beat(8'd225, 1'b0);
      a_beat(8'd225, 1'b0);
      a_beat(8'd225, 1'b0);
      check("full_valid_early", 32'(a_out_valid), 0);
      check("full_count_3", 32'(a_out_count), 3);
      a_beat(8'd225, 1'b0);
      a_in_valid = 1'b0;
      check("full_valid", 32'(a_out_valid), 1);
      check("full_sum", 32'(a_out_sum), 900);
      check("full_count", 32'(a_out_count), 4);
      check("full_ovf", 32'(a_out_ovf), 0);
      check("full_in_ready", 32'(a_in_ready), 0);
      step();
      check("full_back_idle", 32'(a_out_valid), 0);
      check("full_idle_ready", 32'(a_in_ready), 1);

      // in_last without in_valid is ignored
      a_in_last = 1'b1;
      step();
      check("last_novalid", 32'(a_out_valid), 0);
      check("last_novalid_cnt", 32'(a_out_count), 0);

      // Early close on in_last
      a_beat(8'd6, 1'b0);
      a_beat(8'd10, 1'b0);
      a_beat(8'd0, 1'b1);
      a_in_valid = 1'b0;
      check("early_valid", 32'(a_out_valid), 1);
      check("early_sum", 32'(a_out_sum), 16);
      check("early_count", 32'(a_out_count), 3);
      check("early_in_ready", 32'(a_in_ready), 0);
      step();

      // Backpressure: hold 5 cycles, ignore new input
      a_out_ready = 1'b0;
      a_beat(8'd1, 1'b0);
      a_beat(8'd2, 1'b0);
      a_beat(8'd3, 1'b0);
      a_beat(8'd4, 1'b0);
      a_in_valid = 1'b1;
      a_in_prod  = 8'd99;
      a_in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(a_out_valid), 1);
         check("bp_sum", 32'(a_out_sum), 10);
         check("bp_count", 32'(a_out_count), 4);
         check("bp_in_ready", 32'(a_in_ready), 0);
         step();
      end
      a_out_ready = 1'b1;
      step();
      check("bp_release_valid", 32'(a_out_valid), 0);
      check("bp_release_ready", 32'(a_in_ready), 1);
      check("bp_release_cnt", 32'(a_out_count), 0);
      step();
      check("bp_next_valid", 32'(a_out_valid), 1);
      check("bp_next_sum", 32'(a_out_sum), 99);
      check("bp_next_count", 32'(a_out_count), 1);
      a_in_valid = 1'b0;
      step();

      // Asynchronous reset mid-group
      a_beat(8'd50, 1'b0);
      a_beat(8'd60, 1'b0);
      a_in_valid = 1'b0;
      check("mid_sum", 32'(a_out_sum), 110);
      check("mid_count", 32'(a_out_count), 2);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(a_out_valid), 0);
      check("arst_sum", 32'(a_out_sum), 0);
      check("arst_count", 32'(a_out_count), 0);
      #1 rst = 1'b0;
      step();
      a_beat(8'd7, 1'b1);
      a_in_valid = 1'b0;
      check("post_rst_valid", 32'(a_out_valid), 1);
      check("post_rst_sum", 32'(a_out_sum), 7);
      check("post_rst_count", 32'(a_out_count), 1);
      step();

      // Overflow with ACC_W=8: 200+100 wraps to 44
      b_beat(8'd200, 1'b0);
      b_beat(8'd100, 1'b1);
      b_in_valid = 1'b0;
      check("ovf_valid", 32'(b_out_valid), 1);
      check("ovf_sum", 32'(b_out_sum), 44);
      check("ovf_flag", 32'(b_out_ovf), 1);
      check("ovf_count", 32'(b_out_count), 2);
      step();
      b_beat(8'd1, 1'b0);
      b_beat(8'd2, 1'b1);
      b_in_valid = 1'b0;
      check("noovf_sum", 32'(b_out_sum), 3);
      check("noovf_flag", 32'(b_out_ovf), 0);
      step();

      // N_TERMS=1 random stream with random out_ready
      sent = 0;
      recv = 0;
      for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
         c_out_ready = 1'($urandom_range(0, 1));
         if (sent < 20 && !c_in_valid) begin
            c_in_valid = 1'b1;
            c_in_prod  = 8'($urandom_range(0, 255));
            c_in_last  = 1'($urandom_range(0, 1));
         end
         accept = c_in_valid && c_in_ready;
         if (c_out_valid && c_out_ready) begin
            if (exp_q.size() == 0) begin
               check("n1_unexpected", 32'(c_out_sum), 32'hffff_ffff);
            end else begin
               exp_v = exp_q.pop_front();
               check("n1_sum", 32'(c_out_sum), 32'(exp_v));
            end
            check("n1_count", 32'(c_out_count), 1);
            check("n1_ovf", 32'(c_out_ovf), 0);
            recv++;
         end
         if (accept) begin
            exp_q.push_back(c_in_prod);
            sent++;
         end
         step();
         if (accept) begin
            c_in_valid = 1'b0;
         end
      end
      check("n1_received", 32'(recv), 20);
      check("n1_sent", 32'(sent), 20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
